// File: rtl/exh_stim_gen.sv
// Exhaustive stimulus generator: sweeps all 2^WIDTH vectors in binary or Gray order,
// holding each HOLD cycles; optional MISR response compaction under EXH_STIM_MISR_EN.
module exh_stim_gen #(
  parameter int WIDTH     = 5,
  parameter int HOLD      = 1,
  parameter int RWIDTH    = 1,
  parameter int SIG_WIDTH = 16,
  parameter logic [SIG_WIDTH-1:0] SIG_POLY = SIG_WIDTH'(16'h1021)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 mode,
  input  logic [RWIDTH-1:0]    resp,
  output logic [WIDTH-1:0]     vec,
  output logic                 vec_valid,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH:0]       count,
  output logic [SIG_WIDTH-1:0] signature
);

  localparam logic [WIDTH:0] IDX_LAST = {1'b0, {WIDTH{1'b1}}};
  localparam logic [7:0]     HC_LAST  = 8'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic           mode_q;
  logic [WIDTH:0] idx;
  logic [7:0]     hc;
  logic [WIDTH:0] idx_inc;

  assign idx_inc = idx + 1'b1;

  function automatic logic [WIDTH-1:0] code(input logic m, input logic [WIDTH:0] n);
    code = m ? WIDTH'(n ^ (n >> 1)) : n[WIDTH-1:0];
  endfunction

`ifdef EXH_STIM_MISR_EN
  logic [SIG_WIDTH-1:0] sig_next;
  assign sig_next = (signature << 1)
                  ^ (signature[SIG_WIDTH-1] ? SIG_POLY : '0)
                  ^ SIG_WIDTH'(resp);
`else
  logic unused_resp;
  assign unused_resp = ^resp;
  assign signature   = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      idx       <= '0;
      hc        <= '0;
      vec       <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
`ifdef EXH_STIM_MISR_EN
      signature <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state     <= RUN;
            mode_q    <= mode;
            idx       <= '0;
            hc        <= '0;
            count     <= '0;
            vec       <= '0;
            vec_valid <= 1'b1;
            busy      <= 1'b1;
`ifdef EXH_STIM_MISR_EN
            signature <= '0;
`endif
          end
        end
        RUN: begin
          // Last hold cycle of the current vector: sample response and advance.
          if (hc == HC_LAST) begin
            hc    <= '0;
            idx   <= idx_inc;
            count <= count + 1'b1;
`ifdef EXH_STIM_MISR_EN
            signature <= sig_next;
`endif
            if (idx == IDX_LAST) begin
              state     <= DONE;
              done      <= 1'b1;
              busy      <= 1'b0;
              vec_valid <= 1'b0;
              vec       <= '0;
            end else begin
              vec <= code(mode_q, idx_inc);
            end
          end else begin
            hc <= hc + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
